// File: rtl/instr_issue_stall.sv
// Issues a latched 8-instruction program one slot at a time, inserting noop bubbles for RAW hazards.
// Optional macro ISSUE_STALL_CNT_EN enables the stall_cnt bubble counter (tied to zero otherwise).
module instr_issue_stall #(
  parameter int STALL_DIST = 3,
  parameter int NUM_INSTR  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] prog_in,
  output logic [7:0]  instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        bubble,
  output logic [2:0]  slot_idx,
  output logic        busy,
  output logic        done,
  output logic [7:0]  stall_cnt
);

  localparam int         HIST_LEN  = STALL_DIST - 1;
  localparam logic [2:0] LAST_SLOT = 3'(NUM_INSTR - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r, state_nxt_s;
  logic [63:0]     prog_r, prog_nxt_s;
  logic [2:0]      slot_r, slot_nxt_s;
  logic [1:0]      hist_vld_r, hist_vld_nxt_s;
  logic [1:0][2:0] hist_reg_r, hist_reg_nxt_s;
  logic [7:0]      instr_out_r;
  logic            instr_valid_r, bubble_r, busy_r, done_r;
  logic            accept_s, wr_vld_s, haz_s;
  logic [2:0]      wr_reg_s;
  logic [7:0]      cand_s;

  function automatic logic [7:0] slot_instr(input logic [63:0] prog, input logic [2:0] idx);
    logic [5:0] lsb;
    lsb = {3'd7 - idx, 3'b000};
    return prog[lsb +: 8];
  endfunction

  // lw (11) and add (01) write register A
  function automatic logic [3:0] write_reg(input logic [7:0] instr);
    logic wr;
    wr = (instr[7:6] == 2'b01) || (instr[7:6] == 2'b11);
    return {wr, instr[5:3]};
  endfunction

  function automatic logic raw_hazard(input logic [7:0] instr, input logic [1:0] vld,
                                      input logic [1:0][2:0] regs);
    logic rd_a, rd_b, hz;
    rd_a = (instr[7:6] == 2'b01) || (instr[7:6] == 2'b10);
    rd_b = (instr[7:6] != 2'b00);
    hz   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if ((i < HIST_LEN) && vld[i] &&
          ((rd_a && (instr[5:3] == regs[i])) || (rd_b && (instr[2:0] == regs[i])))) begin
        hz = 1'b1;
      end else begin
        hz = hz;
      end
    end
    return hz;
  endfunction

  assign accept_s             = instr_valid_r & instr_ready;
  assign {wr_vld_s, wr_reg_s} = write_reg(instr_out_r);

  // Next-state: load in IDLE, advance slot/history on accept in ISSUE, single DONE cycle
  always_comb begin
    state_nxt_s    = state_r;
    prog_nxt_s     = prog_r;
    slot_nxt_s     = slot_r;
    hist_vld_nxt_s = hist_vld_r;
    hist_reg_nxt_s = hist_reg_r;
    case (state_r)
      IDLE: begin
        if (load) begin
          state_nxt_s    = ISSUE;
          prog_nxt_s     = prog_in;
          slot_nxt_s     = 3'd0;
          hist_vld_nxt_s = 2'b00;
          hist_reg_nxt_s = 6'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (accept_s) begin
          // a bubble drives 8'h00, which decodes as no write
          hist_vld_nxt_s = {hist_vld_r[0], wr_vld_s};
          hist_reg_nxt_s = {hist_reg_r[0], wr_reg_s};
          if (bubble_r) begin
            state_nxt_s = ISSUE;
          end else begin
            slot_nxt_s  = slot_r + 3'd1;
            state_nxt_s = (slot_r == LAST_SLOT) ? DONE : ISSUE;
          end
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs are precomputed from next state so they come straight from flops
  assign cand_s = slot_instr(prog_nxt_s, slot_nxt_s);
  assign haz_s  = raw_hazard(cand_s, hist_vld_nxt_s, hist_reg_nxt_s);

  // State, history and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      prog_r        <= 64'd0;
      slot_r        <= 3'd0;
      hist_vld_r    <= 2'b00;
      hist_reg_r    <= 6'd0;
      instr_out_r   <= 8'h00;
      instr_valid_r <= 1'b0;
      bubble_r      <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      prog_r        <= prog_nxt_s;
      slot_r        <= slot_nxt_s;
      hist_vld_r    <= hist_vld_nxt_s;
      hist_reg_r    <= hist_reg_nxt_s;
      instr_valid_r <= (state_nxt_s == ISSUE);
      busy_r        <= (state_nxt_s == ISSUE);
      done_r        <= (state_nxt_s == DONE);
      bubble_r      <= (state_nxt_s == ISSUE) && haz_s;
      instr_out_r   <= ((state_nxt_s == ISSUE) && !haz_s) ? cand_s : 8'h00;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [7:0] stall_cnt_r;

  // Saturating count of accepted bubbles, cleared on program load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 8'h00;
    end else if ((state_r == IDLE) && load) begin
      stall_cnt_r <= 8'h00;
    end else if (accept_s && bubble_r && (stall_cnt_r != 8'hFF)) begin
      stall_cnt_r <= stall_cnt_r + 8'h01;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 8'h00;
`endif

  assign instr_out   = instr_out_r;
  assign instr_valid = instr_valid_r;
  assign bubble      = bubble_r;
  assign slot_idx    = slot_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule
